// File: rtl/wb_arbiter_if.sv
// Register-file write arbiter bus: ALU and divider result inputs, merged write port, status.
// Pure signal bundle with no timing of its own; the arbiter sets all latencies.
// Backpressure is div_ready only. ALU writes are always accepted.
interface wb_arbiter_if;
    logic        alu_wen;
    logic [4:0]  alu_waddr;
    logic [31:0] alu_wdata;
    logic        div_valid;
    logic        div_ready;
    logic [4:0]  div_waddr;
    logic [31:0] div_wdata;
    logic        write_en;
    logic [4:0]  write_reg_addr;
    logic [31:0] write_data;
    logic [31:0] busy_mask;
    logic [2:0]  fifo_count;

    // Producer side: drives the result sources and observes the write port.
    modport master (
        output alu_wen, alu_waddr, alu_wdata,
        output div_valid, div_waddr, div_wdata,
        input  div_ready,
        input  write_en, write_reg_addr, write_data,
        input  busy_mask, fifo_count
    );

    // Arbiter side.
    modport slave (
        input  alu_wen, alu_waddr, alu_wdata,
        input  div_valid, div_waddr, div_wdata,
        output div_ready,
        output write_en, write_reg_addr, write_data,
        output busy_mask, fifo_count
    );
endinterface

// File: rtl/wb_arbiter.sv
// Merges ALU and divider results onto one register-file write port; ALU always wins. WB_FIFO_EN selects queued divider path.
// Latency: ALU 1 cycle; divider 2+ cycles via a 4-entry FIFO (WB_FIFO_EN) or 1 cycle direct (default).
// Backpressure: div_ready = fifo_count<4 with WB_FIFO_EN, otherwise div_ready = !alu_wen.
module wb_arbiter (
    input  logic         clk,
    input  logic         rst,
    wb_arbiter_if.slave  bus
);

    // ALU writes to r0 are dropped; they neither win the port nor kill queued entries.
    logic alu_eff;
    assign alu_eff = bus.alu_wen && (bus.alu_waddr != 5'd0);

    // Registered write port
    logic        wen_q,   wen_d;
    logic [4:0]  waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;

    assign bus.write_en       = wen_q;
    assign bus.write_reg_addr = waddr_q;
    assign bus.write_data     = wdata_q;

    // Accepted divider handshake
    logic div_acc;

`ifdef WB_FIFO_EN

    localparam int DEPTH = 4;

    logic [4:0]       ent_addr_q [DEPTH];
    logic [4:0]       ent_addr_d [DEPTH];
    logic [31:0]      ent_data_q [DEPTH];
    logic [31:0]      ent_data_d [DEPTH];
    logic [DEPTH-1:0] live_q,  live_d;
    logic [1:0]       wptr_q,  wptr_d;
    logic [1:0]       rptr_q,  rptr_d;
    logic [2:0]       count_q, count_d;
    logic [31:0]      busy_q,  busy_d;

    logic push;
    logic pop;
    logic head_live;

    // Readiness only looks at registered occupancy, so a pop never opens a slot for the same cycle.
    assign bus.div_ready  = (count_q < 3'd4);
    assign div_acc        = bus.div_valid && bus.div_ready;
    assign push           = div_acc && (bus.div_waddr != 5'd0);
    assign pop            = (count_q != 3'd0) && !alu_eff;
    assign head_live      = live_q[rptr_q];

    assign bus.busy_mask  = busy_q;
    assign bus.fifo_count = count_q;

    // Next FIFO state: kill matching entries on an ALU write, pop the head when the ALU is idle, push accepted results.
    always_comb begin
        ent_addr_d = ent_addr_q;
        ent_data_d = ent_data_q;
        live_d     = live_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q + {2'b00, push} - {2'b00, pop};

        if (alu_eff) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ent_addr_q[i] == bus.alu_waddr) begin
                    live_d[i] = 1'b0;
                end
            end
        end

        // Popped slots lose their live bit so the busy mask only ever sees occupied slots.
        if (pop) begin
            live_d[rptr_q] = 1'b0;
            rptr_d         = rptr_q + 2'd1;
        end

        // An entry arriving alongside an ALU write to the same register is already stale.
        if (push) begin
            ent_addr_d[wptr_q] = bus.div_waddr;
            ent_data_d[wptr_q] = bus.div_wdata;
            live_d[wptr_q]     = !(alu_eff && (bus.div_waddr == bus.alu_waddr));
            wptr_d             = wptr_q + 2'd1;
        end
    end

    // Busy mask is derived from the next FIFO state so it moves in lockstep with the queue.
    always_comb begin
        busy_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_d[i]) begin
                busy_d[ent_addr_d[i]] = 1'b1;
            end
        end
    end

    // Port selection: ALU first, then a live FIFO head; a dead head pops silently.
    always_comb begin
        wen_d   = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (alu_eff) begin
            wen_d   = 1'b1;
            waddr_d = bus.alu_waddr;
            wdata_d = bus.alu_wdata;
        end else if (pop && head_live) begin
            wen_d   = 1'b1;
            waddr_d = ent_addr_q[rptr_q];
            wdata_d = ent_data_q[rptr_q];
        end
    end

    // Control state; reset empties the queue so no queued write ever reaches the port.
    always_ff @(posedge clk) begin
        if (rst) begin
            wen_q   <= 1'b0;
            waddr_q <= 5'd0;
            wdata_q <= 32'd0;
            live_q  <= '0;
            wptr_q  <= 2'd0;
            rptr_q  <= 2'd0;
            count_q <= 3'd0;
            busy_q  <= 32'd0;
        end else begin
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            live_q  <= live_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            busy_q  <= busy_d;
        end
    end

    // Payload storage is not reset; live bits and occupancy gate every use of it.
    always_ff @(posedge clk) begin
        ent_addr_q <= ent_addr_d;
        ent_data_q <= ent_data_d;
    end

`else

    // Without the queue the divider can only take the port when the ALU is not asserting.
    assign bus.div_ready  = !bus.alu_wen;
    assign div_acc        = bus.div_valid && bus.div_ready;
    assign bus.busy_mask  = 32'd0;
    assign bus.fifo_count = 3'd0;

    // Port selection: ALU first, then an accepted non-r0 divider result straight through.
    always_comb begin
        wen_d   = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (alu_eff) begin
            wen_d   = 1'b1;
            waddr_d = bus.alu_waddr;
            wdata_d = bus.alu_wdata;
        end else if (div_acc && (bus.div_waddr != 5'd0)) begin
            wen_d   = 1'b1;
            waddr_d = bus.div_waddr;
            wdata_d = bus.div_wdata;
        end
    end

    // Registered write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            wen_q   <= 1'b0;
            waddr_q <= 5'd0;
            wdata_q <= 32'd0;
        end else begin
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

`endif

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The block SHALL have the following ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- alu_wen  in  1  ALU result valid this cycle; always accepted
- alu_waddr  in  5  ALU destination register
- alu_wdata  in  32  ALU result
- div_valid  in  1  divider result offered
- div_ready  out  1  arbiter accepts divider result
- div_waddr  in  5  divider destination register
- div_wdata  in  32  divider result
- write_en  out  1  register-file write enable
- write_reg_addr  out  5  register-file write address
- write_data  out  32  register-file write data
- busy_mask  out  32  bit n set = a divider write to register n is pending
- fifo_count  out  3  pending divider entries, 0..4

Function
REQ-002 The clock SHALL be clk, and reset SHALL be rst, synchronous, active-high.
REQ-003 write_en, write_reg_addr and write_data SHALL be registered, one cycle after the winning source is selected.
REQ-004 An ALU write with alu_waddr==0 SHALL be treated as no write.
REQ-005 An accepted divider write with div_waddr==0 SHALL be discarded (not enqueued).
REQ-006 A divider handshake SHALL occur when div_valid and div_ready are both 1; div_ready SHALL equal (fifo_count<4), combinational from registered state.
REQ-007 When full, a pop SHALL NOT free a slot for a push in the same cycle; div_ready stays 0 that cycle.
REQ-008 Accepted divider results SHALL enter a 4-entry in-order FIFO; there SHALL be no direct path, so minimum divider-to-write latency is 2 cycles.
REQ-009 Selection priority each cycle SHALL be: effective ALU write first; otherwise the FIFO head, if a live entry is present; otherwise no write (write_en=0, address and data hold their last values).
REQ-010 The FIFO head SHALL pop only in a cycle with no effective ALU write.
REQ-011 Each entry SHALL carry a live bit. An effective ALU write to register n SHALL clear the live bit of every queued entry with address n (kill), including an entry enqueued in the same cycle.
REQ-012 Dead entries SHALL still occupy their slot and pop in order, producing write_en=0 in the pop cycle.
REQ-013 busy_mask SHALL be the OR of the decoded addresses of live entries, registered and updated in the same cycle as the FIFO state.
REQ-014 fifo_count SHALL count all entries, live and dead.
REQ-015 Pointers SHALL be 2-bit and wrap from 3 to 0. Simultaneous push and pop when not full SHALL leave fifo_count unchanged.

Reset
REQ-016 On rst, the block SHALL set write_en=0, write_reg_addr=0, write_data=0, busy_mask=0, fifo_count=0, and both pointers to 0.
REQ-017 On rst, div_ready SHALL be 1 in the cycle after reset deasserts.
REQ-018 A reset mid-operation SHALL discard all queued entries without issuing any writes.

Configuration
REQ-019 Macro WB_FIFO_EN SHALL control the FIFO. When defined, the FIFO and kill logic SHALL behave as specified in REQ-006..REQ-015.
REQ-020 When WB_FIFO_EN is not defined:
- div_ready SHALL equal NOT alu_wen.
- An accepted divider result SHALL go directly to the registered write port (1-cycle latency).
- busy_mask and fifo_count SHALL be constant 0.
- No kill logic SHALL exist.

Verification
REQ-021 The bench SHALL cover these scenarios (WB_FIFO_EN defined unless stated):
- ALU only: alu_wen=1, addr=5, data=0x1234 -> next cycle write_en=1, addr=5, data=0x1234.
- Collision: ALU addr=3 and divider addr=7 (data 0xAA) in the same cycle, ALU idle afterwards -> cycle+1 writes r3; cycle+2 writes r7=0xAA; busy_mask bit7 is high for exactly 1 cycle.
- Kill: divider result r9=0x11 queued behind busy ALU cycles, then ALU writes r9=0x22 -> r9 final value is 0x22, the dead pop gives write_en=0, and busy_mask bit9 clears with the ALU write.
- Full: ALU busy 6 cycles while div_valid=1 -> 4 accepts, then div_ready=0 and fifo_count=4. When the ALU goes idle, entries drain in order at one per cycle.
- Zero register: ALU addr=0, or an accepted divider addr=0 -> no write_en pulse, and fifo_count does not increment.
- Reset with 3 entries queued -> the next cycle has fifo_count=0, busy_mask=0, and no writes. Without WB_FIFO_EN: alu_wen=1 and div_valid=1 give div_ready=0, then with alu_wen=0 the divider write appears 1 cycle later.
